dmem_port_arbiter: RTL

//  Shares the single data-memory port (MEM_DATA) between the pipeline MEM stage (CPU) and an

---
 rtl/dmem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-memory port between the pipeline MEM stage (CPU)
// and an auxiliary requester (program loader / debug DMA). The CPU normally
// wins; a starvation counter forces one AUX slot after STARVE_MAX denied
// cycles, and the CPU is stalled for that slot.
module dmem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // CPU (MEM stage) side
  input  logic             i_cpu_read,
  input  logic             i_cpu_write,
  input  logic [WIDTH-1:0] i_cpu_addr,
  input  logic [WIDTH-1:0] i_cpu_wdata,
  output logic [WIDTH-1:0] o_cpu_rdata,
  output logic             o_stall,
  // AUX requester side
  input  logic             i_aux_valid,
  input  logic             i_aux_we,
  input  logic [WIDTH-1:0] i_aux_addr,
  input  logic [WIDTH-1:0] i_aux_wdata,
  output logic             o_aux_ready,
  output logic             o_aux_rvalid,
  output logic [WIDTH-1:0] o_aux_rdata,
  // Memory port
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Last owner of the port; AUX_RD drives the read-response pulse.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU    = 2'd1,
    ST_AUX_RD = 2'd2,
    ST_AUX_WR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_AUX  = 2'd2
  } grant_t;

  state_t           state, state_next;
  grant_t           grant;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next, cnt_eff;
  logic             cpu_req;
  logic             force_aux;
  logic             aux_hs;

  assign cpu_req = i_cpu_read | i_cpu_write;

  // During the reset cycle the counter is treated as already cleared, so the
  // grant decision never forces AUX off a stale count.
  assign cnt_eff   = i_rst ? '0 : starve_cnt;
  assign force_aux = (cnt_eff == STARVE_LIM) & i_aux_valid;
  assign aux_hs    = (grant == GNT_AUX);

  assign o_cpu_rdata  = i_mem_rdata;
  assign o_aux_rvalid = (state == ST_AUX_RD);

  // Grant decision and memory-port steering.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path leaves one unassigned (which would infer a latch).
    grant       = GNT_NONE;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_stall     = 1'b0;
    o_aux_ready = 1'b0;
    if (cpu_req && !force_aux) begin
      grant       = GNT_CPU;
      o_mem_read  = i_cpu_read;
      o_mem_write = i_cpu_write;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (i_aux_valid) begin
      grant       = GNT_AUX;
      o_mem_read  = !i_aux_we;
      o_mem_write = i_aux_we;
      o_mem_addr  = i_aux_addr;
      o_mem_wdata = i_aux_wdata;
      o_aux_ready = 1'b1;
      o_stall     = cpu_req;
    end
  end

  // Next owner state and next starvation count.
  always_comb begin
    state_next      = ST_IDLE;
    starve_cnt_next = starve_cnt;
    unique case (grant)
      GNT_CPU: state_next = ST_CPU;
      GNT_AUX: state_next = i_aux_we ? ST_AUX_WR : ST_AUX_RD;
      default: state_next = ST_IDLE;
    endcase
    if (!i_aux_valid || aux_hs) begin
      starve_cnt_next = '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  // State and starvation-count registers.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // AUX read-data capture; holds its value between responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_aux_rdata <= '0;
    end else if (aux_hs && !i_aux_we) begin
      o_aux_rdata <= i_mem_rdata;
    end
  end

endmodule
